// File: rtl/piso_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : piso_frame_tx
// Description : Parallel-in, serial-out frame transmitter. Accepts a word on
//               a valid/ready handshake and emits start bit, data bits,
//               optional parity bit and stop bit, each held for CLK_DIV
//               clocks. so_valid strobes once per data bit for the
//               downstream serial-in shifter.
// Revision    : 1.0 - initial release
// ============================================================================
module piso_frame_tx #(
    parameter int WIDTH      = 8,
    parameter int CLK_DIV    = 4,
    parameter int MSB_FIRST  = 0,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             so,
    output logic             so_valid,
    output logic             busy,
    output logic             frame_done
);

    // Counter widths never drop below one bit so CLK_DIV=1 / WIDTH=1 still work
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [DIV_W-1:0] c_div_last = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] c_bit_last = BIT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [DIV_W-1:0]   r_div_cnt;
    logic [BIT_W-1:0]   r_bit_cnt;
    logic [WIDTH-1:0]   r_shift;
    logic               r_par;

    logic               w_div_last;
    logic               w_xfer;
    logic               w_data_bit;

    assign w_div_last = (r_div_cnt == c_div_last);
    assign w_xfer     = din_valid && din_ready;
    // The bit currently presented always sits at the outgoing end of the shifter
    assign w_data_bit = (MSB_FIRST != 0) ? r_shift[WIDTH-1] : r_shift[0];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and outputs decoded from registered state
    always_comb begin
        w_state_nxt = r_state;
        so          = 1'b1;
        so_valid    = 1'b0;
        busy        = 1'b1;
        frame_done  = 1'b0;
        din_ready   = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy      = 1'b0;
                din_ready = 1'b1;
                if (din_valid) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                so = 1'b0;
                if (w_div_last) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                so       = w_data_bit;
                so_valid = w_div_last;
                if (w_div_last && (r_bit_cnt == c_bit_last)) begin
                    w_state_nxt = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                so = r_par;
                if (w_div_last) begin
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                frame_done = w_div_last;
                din_ready  = w_div_last;
                if (w_div_last) begin
                    // A word accepted in the last stop clock starts with no idle gap
                    w_state_nxt = din_valid ? S_START : S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath: word latch, parity, bit-period divider and data-bit counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_par     <= 1'b0;
        end else if (w_xfer) begin
            r_shift   <= din;
            r_par     <= (^din) ^ (PARITY_ODD != 0);
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
        end else if (r_state != S_IDLE) begin
            if (w_div_last) begin
                r_div_cnt <= '0;
                if (r_state == S_DATA) begin
                    r_shift   <= (MSB_FIRST != 0) ? (r_shift << 1) : (r_shift >> 1);
                    r_bit_cnt <= (r_bit_cnt == c_bit_last) ? '0 : r_bit_cnt + BIT_W'(1);
                end
            end else begin
                r_div_cnt <= r_div_cnt + DIV_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_piso_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_piso_frame_tx
// Description : Self-checking bench for piso_frame_tx. Three instances:
//               dut0 default (LSB first, even parity, CLK_DIV=4),
//               dut1 MSB first, dut2 odd parity with CLK_DIV=1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_frame_tx;

    logic       clk;
    logic       rst;
    logic [7:0] din_a   [3];
    logic       vld_a   [3];
    logic       rdy_a   [3];
    logic       so_a    [3];
    logic       sv_a    [3];
    logic       busy_a  [3];
    logic       fd_a    [3];

    int cdiv_of [3] = '{4, 4, 1};
    bit msb_of  [3] = '{1'b0, 1'b1, 1'b0};
    bit odd_of  [3] = '{1'b0, 1'b0, 1'b1};

    int n_cmp = 0;
    int n_bad = 0;

    piso_frame_tx #(.WIDTH(8), .CLK_DIV(4), .MSB_FIRST(0), .PARITY_EN(1), .PARITY_ODD(0)) u_dut0 (
        .clk(clk), .rst(rst), .din(din_a[0]), .din_valid(vld_a[0]), .din_ready(rdy_a[0]),
        .so(so_a[0]), .so_valid(sv_a[0]), .busy(busy_a[0]), .frame_done(fd_a[0]));

    piso_frame_tx #(.WIDTH(8), .CLK_DIV(4), .MSB_FIRST(1), .PARITY_EN(1), .PARITY_ODD(0)) u_dut1 (
        .clk(clk), .rst(rst), .din(din_a[1]), .din_valid(vld_a[1]), .din_ready(rdy_a[1]),
        .so(so_a[1]), .so_valid(sv_a[1]), .busy(busy_a[1]), .frame_done(fd_a[1]));

    piso_frame_tx #(.WIDTH(8), .CLK_DIV(1), .MSB_FIRST(0), .PARITY_EN(1), .PARITY_ODD(1)) u_dut2 (
        .clk(clk), .rst(rst), .din(din_a[2]), .din_valid(vld_a[2]), .din_ready(rdy_a[2]),
        .so(so_a[2]), .so_valid(sv_a[2]), .busy(busy_a[2]), .frame_done(fd_a[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame vectors: bits[10] is the first bit on the line, bits[0] the stop bit
    typedef struct {
        int         d;
        logic [7:0] w;
        logic [10:0] bits;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string nm, input int d, input int cyc, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d cyc%0d: got %b expected %b", nm, d, cyc, act, exp);
        end
    endtask

    // Reference frame from the framing rules: start, ordered data, parity, stop
    function automatic logic [10:0] model(input logic [7:0] w, input bit msb, input bit odd);
        logic [10:0] f;
        int ones;
        ones  = 0;
        f[10] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            f[9-i] = msb ? w[7-i] : w[i];
            ones += int'(w[i]);
        end
        f[1] = ((ones % 2) == 1) ^ odd;
        f[0] = 1'b1;
        return f;
    endfunction

    task automatic idle_chk(input int d);
        chk("idle_so", d, -1, so_a[d], 1'b1);
        chk("idle_busy", d, -1, busy_a[d], 1'b0);
        chk("idle_ready", d, -1, rdy_a[d], 1'b1);
        chk("idle_so_valid", d, -1, sv_a[d], 1'b0);
        chk("idle_frame_done", d, -1, fd_a[d], 1'b0);
    endtask

    // Present a word while idle; returns at the first START clock
    task automatic start_word(input int d, input logic [7:0] w);
        idle_chk(d);
        din_a[d] = w;
        vld_a[d] = 1'b1;
        @(negedge clk);
    endtask

    // Check one whole frame clock by clock, starting at its first START clock.
    // At clock apply_at the upstream switches to (nvalid, nword).
    task automatic run_frame(input int d, input logic [10:0] bits, input int apply_at,
                             input logic nvalid, input logic [7:0] nword);
        int cd;
        int len;
        int k;
        bit last;
        cd  = cdiv_of[d];
        len = cd * 11;
        for (int c = 0; c < len; c++) begin
            k    = c / cd;
            last = ((c % cd) == cd - 1);
            if (c == apply_at) begin
                din_a[d] = nword;
                vld_a[d] = nvalid;
            end
            chk("so", d, c, so_a[d], bits[10-k]);
            chk("so_valid", d, c, sv_a[d], logic'(k >= 1 && k <= 8 && last));
            chk("frame_done", d, c, fd_a[d], logic'(k == 10 && last));
            chk("busy", d, c, busy_a[d], 1'b1);
            chk("din_ready", d, c, rdy_a[d], logic'(k == 10 && last));
            @(negedge clk);
        end
    endtask

    initial begin
        logic [7:0] w;
        logic [7:0] nw;
        bit         pend;
        bit         b2b;
        int         at;

        tbl[0] = '{0, 8'hA5, 11'b01010010101};
        tbl[1] = '{1, 8'h80, 11'b01000000011};
        tbl[2] = '{2, 8'h00, 11'b00000000011};
        tbl[3] = '{0, 8'h5A, 11'b00101101001};
        tbl[4] = '{2, 8'hA5, 11'b01010010111};

        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            din_a[d] = 8'h00;
            vld_a[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) idle_chk(d);
        rst = 1'b0;
        @(negedge clk);

        // Directed single frames
        for (int i = 0; i < 5; i++) begin
            start_word(tbl[i].d, tbl[i].w);
            run_frame(tbl[i].d, tbl[i].bits, 0, 1'b0, 8'h00);
            idle_chk(tbl[i].d);
        end

        // Back-to-back: 3C then FF with valid held high
        start_word(0, 8'h3C);
        run_frame(0, 11'b00011110001, 0, 1'b1, 8'hFF);
        run_frame(0, 11'b01111111101, 0, 1'b0, 8'h00);
        idle_chk(0);

        // New word offered mid-frame waits for the last stop clock
        start_word(0, 8'hA5);
        run_frame(0, 11'b01010010101, 10, 1'b1, 8'h00);
        run_frame(0, 11'b00000000001, 0, 1'b0, 8'h00);
        idle_chk(0);

        // Reset during the 3rd data bit abandons the frame
        start_word(0, 8'hA5);
        vld_a[0] = 1'b0;
        repeat (13) @(negedge clk);
        chk("pre_rst_busy", 0, 13, busy_a[0], 1'b1);
        rst = 1'b1;
        @(negedge clk);
        idle_chk(0);
        rst = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            chk("post_rst_frame_done", 0, c, fd_a[0], 1'b0);
            chk("post_rst_so", 0, c, so_a[0], 1'b1);
        end
        start_word(0, 8'h5A);
        run_frame(0, 11'b00101101001, 0, 1'b0, 8'h00);
        idle_chk(0);

        // Random words against the reference model, with random back-to-back
        for (int d = 0; d < 3; d++) begin
            pend = 1'b0;
            nw   = 8'h00;
            for (int i = 0; i < 15; i++) begin
                w = pend ? nw : 8'($urandom);
                if (!pend) start_word(d, w);
                b2b = (i < 14) && ($urandom_range(1, 0) == 1);
                nw  = 8'($urandom);
                at  = $urandom_range(cdiv_of[d] * 11 - 1, 0);
                run_frame(d, model(w, msb_of[d], odd_of[d]), b2b ? at : 0, b2b, b2b ? nw : 8'h00);
                pend = b2b;
            end
            idle_chk(d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
